// File: rtl/nerv_dmem_bridge.sv
// nerv_dmem_bridge
//
// Connects the NERV core data port to a request/response system bus with
// wait states. Each core access is latched, issued on the bus with a
// valid/ready request, and completed when the separate response arrives.
// The core is held with a combinational stall until then. Load data is held
// in a register so that it stays stable through the core's write-back cycle.
// The replayed load the core presents in that cycle is ignored.
//
// Optional feature: define NERV_DMEM_BRIDGE_TIMEOUT_EN to add a response
// timeout counter and the sticky bus_err output.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   dmem_valid        core access request
//   dmem_addr         word-aligned address
//   dmem_wstrb        byte write strobes, 0 = read
//   dmem_wdata        write data, already lane-shifted
//   dmem_rdata        read data to the core (held register)
//   stall             hold to the core; no combinational path from bus inputs
//   bus_valid/ready   request handshake
//   bus_addr/wstrb/wdata  request payload, registered
//   bus_rvalid        response strobe for reads and writes
//   bus_rdata         response data, used for reads only
//   bus_err           sticky timeout flag (timeout build only)
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; an eligible dmem_valid is captured here
// REQ   | bus_valid driven, waiting for bus_ready
// RESP  | request accepted, waiting for bus_rvalid (or timeout)
// DONE  | stall released, core commits the access
// WB    | load write-back cycle; the replayed load request is ignored

module nerv_dmem_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic        bus_rvalid,
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
  input  logic [31:0] bus_rdata,
  output logic        bus_err
`else
  input  logic [31:0] bus_rdata
`endif
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("nerv_dmem_bridge: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_DONE = 3'd3,
    ST_WB   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        is_read_q, is_read_d;
  logic        suppress_q, suppress_d;
  logic        eligible;

`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
`endif

  // The core's request in the first cycle after reset is not a real access.
  assign eligible = dmem_valid && !suppress_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    is_read_d  = is_read_q;
    suppress_d = 1'b0;
    stall      = 1'b0;
    bus_valid  = 1'b0;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (eligible) begin
          stall     = 1'b1;
          addr_d    = dmem_addr;
          wstrb_d   = dmem_wstrb;
          wdata_d   = dmem_wdata;
          is_read_d = (dmem_wstrb == 4'b0000);
          state_d   = ST_REQ;
        end
      end

      ST_REQ: begin
        stall     = 1'b1;
        bus_valid = 1'b1;
        if (bus_ready) begin
          state_d = ST_RESP;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
          tmo_cnt_d = 16'd0;
`endif
        end
      end

      ST_RESP: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          if (is_read_q) begin
            rdata_d = bus_rdata;
          end
          state_d = ST_DONE;
        end
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
        // Counter would reach TIMEOUT_CYCLES on this empty cycle: expire now.
        // A response in the same cycle wins via the branch above.
        else if (tmo_cnt_q == TMO_LAST) begin
          if (is_read_q) begin
            rdata_d = 32'hFFFF_FFFF;
          end
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end

      ST_DONE: begin
        state_d = is_read_q ? ST_WB : ST_IDLE;
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
      is_read_q  <= 1'b0;
      suppress_q <= 1'b1;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
      tmo_cnt_q  <= 16'd0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_read_q  <= is_read_d;
      suppress_q <= suppress_d;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      err_q      <= err_d;
`endif
    end
  end

  assign dmem_rdata = rdata_q;
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;
`ifdef NERV_DMEM_BRIDGE_TIMEOUT_EN
  assign bus_err    = err_q;
`endif

endmodule

// File: doc/nerv_dmem_bridge.md
# nerv_dmem_bridge

Bridge between the NERV core data port and a wait-state, request/response system bus. It sits directly downstream of the core. It latches each core data access, runs it on the bus with a valid/ready request and a separate response, and holds the core with `stall` until the access completes. Read data is held stable for the core's load write-back cycle, and the core's replayed load request in that cycle is suppressed.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: response wait limit in cycles, counted from request acceptance. Range 1..65535. Used only when the timeout feature is compiled in.

Ports:
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dmem_valid` in 1: core data access request.
- `dmem_addr` in 32: word-aligned address.
- `dmem_wstrb` in 4: byte write strobes; 0 means read.
- `dmem_wdata` in 32: write data, already lane-shifted.
- `dmem_rdata` out 32: read data to the core; driven from the held register.
- `stall` out 1: combinational hold to the core.
- `bus_valid` out 1: request valid.
- `bus_ready` in 1: request accepted when high together with `bus_valid`.
- `bus_addr` out 32, `bus_wstrb` out 4, `bus_wdata` out 32: request payload.
- `bus_rvalid` in 1: response valid; acknowledges both reads and writes.
- `bus_rdata` in 32: response data; ignored for writes.
- `bus_err` out 1: sticky timeout flag. Present only with `NERV_DMEM_BRIDGE_TIMEOUT_EN`.

## Operation
The state machine has five states: IDLE, REQ, RESP, DONE and WB.

- **IDLE**
  - An access is *eligible* when `dmem_valid` is high and the suppress flag is clear.
  - On an eligible access: `stall`=1. Capture addr, wstrb and wdata into payload registers, capture `is_read = (dmem_wstrb==0)`, then go to REQ.
  - Otherwise `stall`=0.
- **REQ**
  - `stall`=1 and `bus_valid`=1, with the payload driven from the registers.
  - On `bus_ready`, go to RESP.
  - Payload and `bus_valid` stay stable until accepted.
- **RESP**
  - `stall`=1. `bus_rvalid` is sampled only in this state.
  - On `bus_rvalid`: if `is_read`, load `rdata_q <= bus_rdata`. Then go to DONE.
- **DONE**
  - `stall`=0 and the core commits the access.
  - If `is_read`, go to WB; otherwise go to IDLE.
- **WB**
  - `stall`=0. The core writes back `dmem_rdata` and re-presents the same load; this request is ignored.
  - Go to IDLE.
- **Suppress flag**
  - Set in the first cycle after `reset` falls. The core does not commit in that cycle and its request is not real.
  - Cleared after that one cycle.
- **Read data**
  - `dmem_rdata` = `rdata_q` at all times.
  - `rdata_q` changes only on a read response.
- **Bus responses outside RESP**
  - `bus_rvalid` in IDLE, REQ, DONE or WB is ignored. This covers stale responses after a reset.

## Timing
- **Reset values:** state=IDLE, `stall`=0, `bus_valid`=0, `bus_addr`/`bus_wstrb`/`bus_wdata`=0, `rdata_q`=0, `bus_err`=0, suppress=1 (asserted in the cycle after reset).
- **Reset mid-transaction:** the access is abandoned and the bridge returns to IDLE the next cycle. A pending bus response is dropped.
- **Cycle-level sequence, with T0 the cycle `dmem_valid` is first eligible:**
  - T0: `stall`=1.
  - T1 onward: `bus_valid`=1 until the handshake.
  - If `bus_ready` is high at T1, RESP starts at T2; the earliest `bus_rvalid` sampled is T2.
  - The minimum access is DONE at T3, meaning 3 stalled cycles (T0–T2).
  - Each additional cycle of `bus_ready` or `bus_rvalid` delay adds one stall cycle.
- **Back-to-back accesses:**
  - After a write DONE, a new `dmem_valid` in the next cycle (IDLE) is eligible immediately.
  - After a read, the earliest next eligible access is the cycle after WB.
- **Stall signal:** `stall` is a combinational function of the state and of `dmem_valid` in IDLE. There is no path from the bus inputs to `stall`.

## Configuration
`NERV_DMEM_BRIDGE_TIMEOUT_EN`:
- **Defined:**
  - A 16-bit counter clears on entering RESP and increments each RESP cycle without `bus_rvalid`.
  - When it reaches `TIMEOUT_CYCLES`, go to DONE with `rdata_q <= 32'hFFFF_FFFF` for reads, and set `bus_err`.
  - `bus_err` clears only on reset.
  - `bus_rvalid` in the expiry cycle takes precedence and is a normal completion.
- **Undefined:** no counter and no `bus_err` port. RESP waits indefinitely.

## Test plan
- **Read, zero wait:** `dmem_valid`=1, `dmem_wstrb`=0, addr `0x100`; `bus_ready`=1 at T1, `bus_rvalid`=1 with `0xDEADBEEF` at T2.
  - `stall` high for exactly T0–T2.
  - `dmem_rdata`=`0xDEADBEEF` at T3 and T4.
  - No second bus request in T4 despite `dmem_valid`=1.
- **Write with wait states:** wstrb `0x4`, wdata `0x00AB0000`, addr `0x200`; `bus_ready` delayed 2 cycles, `bus_rvalid` delayed 3 cycles.
  - `bus_valid` held for 3 cycles with a stable payload.
  - 8 stall cycles in total.
  - `dmem_rdata` unchanged.
- **Write then read back-to-back:** the read is asserted in the cycle after write DONE.
  - The read's `bus_valid` rises the following cycle with no extra bubble.
- **Reset in RESP:** `bus_rvalid` arrives 2 cycles after reset falls.
  - The response is ignored.
  - `stall`=0 and `bus_valid`=0.
  - `dmem_valid` in the first post-reset cycle does not start an access.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=4):** a read with no `bus_rvalid`.
  - DONE occurs after 4 RESP cycles.
  - `dmem_rdata`=`0xFFFFFFFF` and `bus_err`=1 until reset.
